vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  H_VISIBLE 640 visible pixels/line; H_FP 16 front porch; H_SYNC 96 sync width; H_BP 48 back porch (line total 800).
  V_VISIBLE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33 (frame total 525).
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk_i input 1 pixel-domain clock.
  rst_i input 1 reset.
  pix_en_i input 1 pixel-rate enable; tie 1 when clk_i is 25 MHz.
  rgb_i input 3 colour from the pattern generator for the current row_o/column_o.
  column_o output 10 horizontal counter, 0..799.
  row_o output 10 vertical counter, 0..524.
  video_on_o output 1 high when column_o<640 and row_o<480.
  hsync_o output 1 horizontal sync, active low.
  vsync_o output 1 vertical sync, active low.
  rgb_o output 3 blank-gated colour to the DAC pins.
  frame_start_o output 1 one-cycle frame pulse.
REQ-003 The block SHALL use one clock, clk_i; rst_i SHALL be synchronous and active-high.

Function
REQ-004 column_o SHALL be a register that increments by 1 on each clk_i edge with pix_en_i=1, and wraps 799->0.
REQ-005 row_o SHALL increment by 1 only on the cycle column_o wraps, and wrap 524->0 when column_o and row_o wrap together.
REQ-006 With pix_en_i=0, all registers (counters, syncs, rgb_o) SHALL hold their values; frame_start_o SHALL be 0.
REQ-007 video_on_o SHALL be combinational from column_o/row_o, with zero latency relative to the counters.
REQ-008 hsync_o SHALL be registered, with one enabled cycle of latency. It SHALL be 0 on the enabled cycle after column_o was in [656,751], and 1 otherwise.
REQ-009 vsync_o SHALL be registered, with one enabled cycle of latency. It SHALL be 0 on the enabled cycle after row_o was in [490,491], and 1 otherwise.
REQ-010 rgb_o SHALL be registered, with one enabled cycle of latency. It SHALL load rgb_i when video_on_o=1 and 3'b000 otherwise, so rgb_o, hsync_o and vsync_o stay aligned.
REQ-011 frame_start_o SHALL pulse 1 for exactly one clk_i cycle on the enabled edge where the counters go from (799,524) to (0,0).
REQ-012 Sync boundaries SHALL derive from the parameters: start=VISIBLE+FP, end=VISIBLE+FP+SYNC-1. All comparisons SHALL be unsigned, 10-bit.
REQ-013 Counters SHALL never take values at or beyond the line or frame totals. pix_en_i asserted at the wrap point SHALL cause no skipped or repeated count.

Reset
REQ-014 While rst_i=1 at a clk_i edge, regardless of pix_en_i: column_o=0, row_o=0, hsync_o=1, vsync_o=1, rgb_o=3'b000, frame_start_o=0.
REQ-015 Reset asserted mid-frame SHALL restart timing at (0,0) on the next edge. No sync pulse or frame_start_o SHALL be generated by the reset itself.
REQ-016 On the first enabled edge after rst_i falls, the counters SHALL go to (1,0).

Structure
REQ-017 The timing constants, colour constants (BLACK 3'b000, etc.) and derived totals SHALL live in a shared package, vga_timing_pkg. pattgen blocks and vga_sync_gen SHALL both import it.
REQ-018 One sub-module, vga_axis_counter (parameterised modulus, enable in, wrap-pulse out), SHALL be instantiated twice: horizontal, and vertical enabled by the horizontal wrap.
REQ-019 The implementation SHALL contain no latches and no combinational paths from rgb_i to any output.

Verification
REQ-020 Reset: hold rst_i=1 for 3 cycles, then release -> counters (0,0), hsync_o=vsync_o=1, rgb_o=000; first enabled edge gives column_o=1.
REQ-021 Line timing: pix_en_i=1 for 800 cycles -> hsync_o low for exactly 96 consecutive cycles, first low cycle immediately after column_o=656; row_o increments once.
REQ-022 Frame timing: run 2 frames -> frame_start_o pulses are exactly 420000 cycles apart; vsync_o is low for exactly 1600 cycles per frame.
REQ-023 Blanking: rgb_i=3'b111 constant -> rgb_o=111 on exactly 307200 cycles per frame, 000 elsewhere; rgb_o nonzero never coincides with hsync_o=0 or vsync_o=0.
REQ-024 Enable: pix_en_i toggling 1,0,1,0 -> all periods double; registers hold on pix_en_i=0 cycles; frame_start_o never asserted on a pix_en_i=0 cycle.
REQ-025 Mid-frame reset: assert rst_i at column_o=300, row_o=200 with pix_en_i=1 -> next edge (0,0); no frame_start_o pulse; subsequent frame is the full 420000 cycles.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing and colour constants for the sync generator and pattern generators.
package vga_timing_pkg;

  localparam int unsigned CNT_W = 10;
  localparam int unsigned RGB_W = 3;

  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FP      = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BP      = 48;
  localparam int unsigned VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FP      = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BP      = 33;
  localparam int unsigned VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef logic [RGB_W-1:0] rgb_t;

  localparam rgb_t BLACK   = 3'b000;
  localparam rgb_t BLUE    = 3'b001;
  localparam rgb_t GREEN   = 3'b010;
  localparam rgb_t CYAN    = 3'b011;
  localparam rgb_t RED     = 3'b100;
  localparam rgb_t MAGENTA = 3'b101;
  localparam rgb_t YELLOW  = 3'b110;
  localparam rgb_t WHITE   = 3'b111;

  // Inclusive unsigned window test used for both sync pulses.
  function automatic logic in_range(input logic [CNT_W-1:0] v,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Pixel-side bundle of the VGA sync generator: enable/colour in, timing and DAC signals out.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic             pix_en_i;
  rgb_t             rgb_i;
  logic [CNT_W-1:0] column_o;
  logic [CNT_W-1:0] row_o;
  logic             video_on_o;
  logic             hsync_o;
  logic             vsync_o;
  rgb_t             rgb_o;
  logic             frame_start_o;

  modport slave (
    input  pix_en_i, rgb_i,
    output column_o, row_o, video_on_o, hsync_o, vsync_o, rgb_o, frame_start_o
  );

  modport master (
    output pix_en_i, rgb_i,
    input  column_o, row_o, video_on_o, hsync_o, vsync_o, rgb_o, frame_start_o
  );
endinterface

// File: rtl/vga_axis_counter.sv
// Modulo-MODULUS up counter with enable; o_wrap_c flags the enabled cycle that wraps to 0.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned MODULUS = VGA_H_TOTAL
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_wrap_c
);

  logic [CNT_W-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = (r_count == CNT_W'(MODULUS - 1));
  assign o_wrap_c = i_en & w_at_max;
  assign o_count  = r_count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_at_max ? '0 : r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: column/row counters, registered syncs and blank-gated colour.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
  parameter int unsigned H_FP      = VGA_H_FP,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BP      = VGA_H_BP,
  parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
  parameter int unsigned V_FP      = VGA_V_FP,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BP      = VGA_V_BP
) (
  input  logic           clk_i,
  input  logic           rst_i,
  vga_sync_gen_if.slave  bus
);

  localparam int unsigned H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FP;
  localparam int unsigned H_SYNC_END   = H_VISIBLE + H_FP + H_SYNC - 1;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FP;
  localparam int unsigned V_SYNC_END   = V_VISIBLE + V_FP + V_SYNC - 1;

  logic [CNT_W-1:0] w_column;
  logic [CNT_W-1:0] w_row;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic             w_video_on;
  logic             r_hsync;
  logic             r_vsync;
  rgb_t             r_rgb;

  vga_axis_counter #(.MODULUS(H_TOTAL)) u_h_counter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_en     (bus.pix_en_i),
    .o_count  (w_column),
    .o_wrap_c (w_h_wrap)
  );

  // Rows advance only on the enabled cycle the line wraps.
  vga_axis_counter #(.MODULUS(V_TOTAL)) u_v_counter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_en     (w_h_wrap),
    .o_count  (w_row),
    .o_wrap_c (w_v_wrap)
  );

  assign w_video_on = (w_column < CNT_W'(H_VISIBLE)) && (w_row < CNT_W'(V_VISIBLE));

  // Syncs and colour share one pipeline stage so they stay aligned at the pins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_rgb   <= BLACK;
    end else if (bus.pix_en_i) begin
      r_hsync <= ~in_range(w_column, CNT_W'(H_SYNC_START), CNT_W'(H_SYNC_END));
      r_vsync <= ~in_range(w_row, CNT_W'(V_SYNC_START), CNT_W'(V_SYNC_END));
      r_rgb   <= w_video_on ? bus.rgb_i : BLACK;
    end
  end

  assign bus.column_o      = w_column;
  assign bus.row_o         = w_row;
  assign bus.video_on_o    = w_video_on;
  assign bus.hsync_o       = r_hsync;
  assign bus.vsync_o       = r_vsync;
  assign bus.rgb_o         = r_rgb;
  // High during the enabled cycle whose edge takes the counters to (0,0).
  assign bus.frame_start_o = w_v_wrap & ~rst_i;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: full-width lines, shortened frame (9 lines) to bound run time.
module tb_vga_sync_gen;

  localparam int LINE  = 800;
  localparam int VTOT  = 9;
  localparam int FRAME = LINE * VTOT;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  vga_sync_gen_if vif ();

  vga_sync_gen #(
    .V_VISIBLE (4),
    .V_FP      (1),
    .V_SYNC    (2),
    .V_BP      (2)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (vif.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vif.pix_en_i = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [25:0] got;
    rst = 1'b1;
    vif.rgb_i = 3'b111;
    for (int i = 0; i < 3; i++) begin
      vif.pix_en_i = i[0];
      tick();
      got = {vif.column_o, vif.row_o, vif.hsync_o, vif.vsync_o, vif.rgb_o, vif.frame_start_o};
      checks++;
      if (got !== {10'd0, 10'd0, 1'b1, 1'b1, 3'b000, 1'b0}) begin
        failures++;
        $display("FAIL reset_state cycle=%0d got=%h want=%h", i, got,
                 {10'd0, 10'd0, 1'b1, 1'b1, 3'b000, 1'b0});
      end
    end
    rst = 1'b0;
    vif.pix_en_i = 1'b0;
    tick();
    checks++;
    if (vif.column_o !== 10'd0) begin
      failures++;
      $display("FAIL reset_hold_disabled column got=%0d want=0", vif.column_o);
    end
    vif.pix_en_i = 1'b1;
    tick();
    checks++;
    if ({vif.column_o, vif.row_o} !== {10'd1, 10'd0}) begin
      failures++;
      $display("FAIL reset_first_edge got=(%0d,%0d) want=(1,0)", vif.column_o, vif.row_o);
    end
  endtask

  task automatic test_line();
    int low_cnt, falls, first_low_col, seq_err;
    logic prev_h;
    int prev_col;
    do_reset();
    vif.rgb_i = 3'b000;
    low_cnt = 0; falls = 0; first_low_col = -1; seq_err = 0;
    prev_h = 1'b1; prev_col = 0;
    for (int i = 0; i < LINE; i++) begin
      tick();
      if (int'(vif.column_o) != (prev_col + 1) % LINE) seq_err++;
      prev_col = int'(vif.column_o);
      if (vif.hsync_o === 1'b0) begin
        low_cnt++;
        if (prev_h === 1'b1) begin
          falls++;
          if (first_low_col < 0) first_low_col = int'(vif.column_o);
        end
      end
      prev_h = vif.hsync_o;
    end
    checks++;
    if (low_cnt != 96) begin failures++; $display("FAIL hsync_low_count got=%0d want=96", low_cnt); end
    checks++;
    if (falls != 1) begin failures++; $display("FAIL hsync_single_pulse got=%0d want=1", falls); end
    checks++;
    if (first_low_col != 657) begin
      failures++; $display("FAIL hsync_first_low_column got=%0d want=657", first_low_col);
    end
    checks++;
    if (seq_err != 0) begin failures++; $display("FAIL column_sequence errors got=%0d want=0", seq_err); end
    checks++;
    if ({vif.column_o, vif.row_o} !== {10'd0, 10'd1}) begin
      failures++; $display("FAIL line_row_increment got=(%0d,%0d) want=(0,1)", vif.column_o, vif.row_o);
    end
  endtask

  task automatic test_frame();
    int pulses, p0, p1, vlow, hlow, white, overlap, range_err;
    do_reset();
    vif.rgb_i = 3'b111;
    pulses = 0; p0 = -1; p1 = -1; vlow = 0; hlow = 0; white = 0; overlap = 0; range_err = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      #1;
      if (vif.frame_start_o === 1'b1) begin
        if (pulses == 0) p0 = i; else if (pulses == 1) p1 = i;
        pulses++;
      end
      tick();
      if (vif.column_o >= 10'd800 || vif.row_o >= 10'd9) range_err++;
      if (vif.rgb_o !== 3'b000 && (vif.hsync_o === 1'b0 || vif.vsync_o === 1'b0)) overlap++;
      if (i < FRAME) begin
        if (vif.vsync_o === 1'b0) vlow++;
        if (vif.hsync_o === 1'b0) hlow++;
        if (vif.rgb_o === 3'b111) white++;
      end
    end
    checks++;
    if (pulses != 2) begin failures++; $display("FAIL frame_pulse_count got=%0d want=2", pulses); end
    checks++;
    if (p0 != FRAME - 1) begin failures++; $display("FAIL frame_first_pulse got=%0d want=%0d", p0, FRAME - 1); end
    checks++;
    if (p1 - p0 != FRAME) begin failures++; $display("FAIL frame_period got=%0d want=%0d", p1 - p0, FRAME); end
    checks++;
    if (vlow != 1600) begin failures++; $display("FAIL vsync_low_count got=%0d want=1600", vlow); end
    checks++;
    if (hlow != 864) begin failures++; $display("FAIL hsync_low_per_frame got=%0d want=864", hlow); end
    checks++;
    if (white != 2560) begin failures++; $display("FAIL visible_rgb_count got=%0d want=2560", white); end
    checks++;
    if (overlap != 0) begin failures++; $display("FAIL rgb_during_sync got=%0d want=0", overlap); end
    checks++;
    if (range_err != 0) begin failures++; $display("FAIL counter_range got=%0d want=0", range_err); end
  endtask

  task automatic test_enable();
    int pulses, p0, p1, fs_bad, hold_err, hlow;
    logic [24:0] pre, post;
    do_reset();
    vif.rgb_i = 3'b110;
    pulses = 0; p0 = -1; p1 = -1; fs_bad = 0; hold_err = 0; hlow = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      vif.pix_en_i = ~i[0];
      #1;
      if (vif.frame_start_o === 1'b1) begin
        if (vif.pix_en_i === 1'b0) fs_bad++;
        if (pulses == 0) p0 = i; else if (pulses == 1) p1 = i;
        pulses++;
      end
      pre = {vif.column_o, vif.row_o, vif.hsync_o, vif.vsync_o, vif.rgb_o};
      tick();
      post = {vif.column_o, vif.row_o, vif.hsync_o, vif.vsync_o, vif.rgb_o};
      if (i[0] && post !== pre) hold_err++;
      if (i < 2 * FRAME && vif.hsync_o === 1'b0) hlow++;
    end
    vif.pix_en_i = 1'b1;
    checks++;
    if (fs_bad != 0) begin failures++; $display("FAIL enable_frame_start_when_idle got=%0d want=0", fs_bad); end
    checks++;
    if (hold_err != 0) begin failures++; $display("FAIL enable_hold got=%0d want=0", hold_err); end
    checks++;
    if (p0 != 2 * FRAME - 2) begin
      failures++; $display("FAIL enable_first_pulse got=%0d want=%0d", p0, 2 * FRAME - 2);
    end
    checks++;
    if (p1 - p0 != 2 * FRAME) begin
      failures++; $display("FAIL enable_frame_period got=%0d want=%0d", p1 - p0, 2 * FRAME);
    end
    checks++;
    if (hlow != 1728) begin failures++; $display("FAIL enable_hsync_low got=%0d want=1728", hlow); end
  endtask

  task automatic test_mid_reset();
    int first;
    logic [24:0] got;
    do_reset();
    vif.rgb_i = 3'b101;
    repeat (5 * LINE + 300) tick();
    checks++;
    if ({vif.column_o, vif.row_o} !== {10'd300, 10'd5}) begin
      failures++; $display("FAIL midreset_position got=(%0d,%0d) want=(300,5)", vif.column_o, vif.row_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (vif.frame_start_o !== 1'b0) begin
      failures++; $display("FAIL midreset_frame_start got=%b want=0", vif.frame_start_o);
    end
    tick();
    got = {vif.column_o, vif.row_o, vif.hsync_o, vif.vsync_o, vif.rgb_o};
    checks++;
    if (got !== {10'd0, 10'd0, 1'b1, 1'b1, 3'b000}) begin
      failures++; $display("FAIL midreset_state got=%h want=%h", got, {10'd0, 10'd0, 1'b1, 1'b1, 3'b000});
    end
    rst = 1'b0;
    first = -1;
    for (int i = 0; i < FRAME + 10; i++) begin
      #1;
      if (vif.frame_start_o === 1'b1) begin
        first = i;
        break;
      end
      tick();
    end
    checks++;
    if (first != FRAME - 1) begin
      failures++; $display("FAIL midreset_next_frame got=%0d want=%0d", first, FRAME - 1);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    checks = 0;
    failures = 0;
    vif.pix_en_i = 1'b0;
    vif.rgb_i = 3'b000;
    test_reset();
    test_line();
    test_frame();
    test_enable();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
